// File: rtl/game_ctrl.sv
// Breakout game sequencer: serve/play/pause/end-of-game flow, lives, bricks and score.
// Every output is a register updated on frame_clk; key presses are edge-detected.
module game_ctrl #(
   parameter int unsigned LIVES_INIT  = 3,
   parameter int unsigned NUM_BRICKS  = 40,
   parameter int unsigned SERVE_DELAY = 60,
   parameter int unsigned END_HOLD    = 120
) (
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [7:0]  keycode,
   input  logic        ball_miss,
   input  logic        brick_hit,
   output logic        ball_out,
   output logic        ball_run,
   output logic [2:0]  lives,
   output logic [5:0]  bricks_left,
   output logic [15:0] score,
   output logic [2:0]  state,
   output logic        game_over,
   output logic        win
);

   localparam int unsigned KEY_W   = 8;
   localparam int unsigned LIVES_W = 3;
   localparam int unsigned BRICK_W = 6;
   localparam int unsigned SCORE_W = 16;
   localparam int unsigned CNT_W   = 8;

   localparam logic [KEY_W-1:0]   KEY_SPACE  = 8'h2C;
   localparam logic [KEY_W-1:0]   KEY_P      = 8'h13;
   localparam logic [SCORE_W-1:0] SCORE_STEP = 16'd10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4,
      S_WIN   = 3'd5
   } state_t;

   state_t             state_q, state_n;
   logic [KEY_W-1:0]   key_q;
   logic [CNT_W-1:0]   serve_cnt, serve_n;
   logic [CNT_W-1:0]   hold_cnt, hold_n;
   logic [LIVES_W-1:0] lives_n;
   logic [BRICK_W-1:0] bricks_n;
   logic [SCORE_W-1:0] score_n, score_hit;
   logic [SCORE_W:0]   score_sum;
   logic               space_press, p_press;
   logic               ball_out_n, ball_run_n, game_over_n, win_n;

   assign state = state_q;

   // A press is the first frame a key shows up; holding it does not repeat
   assign space_press = (keycode == KEY_SPACE) && (keycode != key_q);
   assign p_press     = (keycode == KEY_P) && (keycode != key_q);

   assign score_sum = {1'b0, score} + {1'b0, SCORE_STEP};
   assign score_hit = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

   always_comb begin
      state_n  = state_q;
      lives_n  = lives;
      bricks_n = bricks_left;
      score_n  = score;
      serve_n  = serve_cnt;
      hold_n   = hold_cnt;

      case (state_q)
         S_IDLE: begin
            lives_n  = LIVES_W'(LIVES_INIT);
            bricks_n = BRICK_W'(NUM_BRICKS);
            score_n  = '0;
            serve_n  = '0;
            hold_n   = '0;
            if (space_press) begin
               state_n = S_SERVE;
               serve_n = CNT_W'(SERVE_DELAY);
            end
         end
         S_SERVE: begin
            serve_n = (serve_cnt == '0) ? '0 : serve_cnt - 8'd1;
            if ((serve_cnt <= 8'd1) || space_press) begin
               state_n = S_PLAY;
               serve_n = '0;
            end
         end
         S_PLAY: begin
            if (brick_hit) begin
               bricks_n = (bricks_left == '0) ? '0 : bricks_left - 6'd1;
               score_n  = score_hit;
            end
            // Winning frame outranks a simultaneous miss, which then costs nothing
            if (brick_hit && (bricks_left <= 6'd1)) begin
               state_n = S_WIN;
               hold_n  = CNT_W'(END_HOLD);
            end else if (ball_miss) begin
               if (lives <= 3'd1) begin
                  lives_n = '0;
                  state_n = S_OVER;
                  hold_n  = CNT_W'(END_HOLD);
               end else begin
                  lives_n = lives - 3'd1;
                  state_n = S_SERVE;
                  serve_n = CNT_W'(SERVE_DELAY);
               end
            end else if (p_press) begin
               state_n = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (p_press) state_n = S_PLAY;
         end
         S_OVER, S_WIN: begin
            if (hold_cnt != '0) begin
               hold_n = hold_cnt - 8'd1;
            end else if (space_press) begin
               state_n  = S_IDLE;
               lives_n  = LIVES_W'(LIVES_INIT);
               bricks_n = BRICK_W'(NUM_BRICKS);
               score_n  = '0;
            end
         end
         default: begin
            state_n  = S_IDLE;
            lives_n  = LIVES_W'(LIVES_INIT);
            bricks_n = BRICK_W'(NUM_BRICKS);
            score_n  = '0;
            serve_n  = '0;
            hold_n   = '0;
         end
      endcase

      ball_out_n  = !((state_n == S_PLAY) || (state_n == S_PAUSE));
      ball_run_n  = (state_n == S_PLAY);
      game_over_n = (state_n == S_OVER);
      win_n       = (state_n == S_WIN);
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         serve_cnt   <= '0;
         hold_cnt    <= '0;
         lives       <= LIVES_W'(LIVES_INIT);
         bricks_left <= BRICK_W'(NUM_BRICKS);
         score       <= '0;
         ball_out    <= 1'b1;
         ball_run    <= 1'b0;
         game_over   <= 1'b0;
         win         <= 1'b0;
      end else begin
         state_q     <= state_n;
         key_q       <= keycode;
         serve_cnt   <= serve_n;
         hold_cnt    <= hold_n;
         lives       <= lives_n;
         bricks_left <= bricks_n;
         score       <= score_n;
         ball_out    <= ball_out_n;
         ball_run    <= ball_run_n;
         game_over   <= game_over_n;
         win         <= win_n;
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expected output snapshots are queued as each
// frame is driven and compared once the frame edge has been taken.
module tb_game_ctrl;

   localparam logic [7:0] SP = 8'h2C;
   localparam logic [7:0] PK = 8'h13;

   typedef struct packed {
      logic [2:0]  st;
      logic        bo;
      logic        br;
      logic        go;
      logic        wn;
      logic [2:0]  lv;
      logic [5:0]  bk;
      logic [15:0] sc;
   } exp_t;

   logic        Reset;
   logic        frame_clk;
   logic [7:0]  keycode;
   logic        ball_miss;
   logic        brick_hit;
   logic        ball_out;
   logic        ball_run;
   logic [2:0]  lives;
   logic [5:0]  bricks_left;
   logic [15:0] score;
   logic [2:0]  state;
   logic        game_over;
   logic        win;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   exp_t e, got;

   game_ctrl dut (
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .keycode     (keycode),
      .ball_miss   (ball_miss),
      .brick_hit   (brick_hit),
      .ball_out    (ball_out),
      .ball_run    (ball_run),
      .lives       (lives),
      .bricks_left (bricks_left),
      .score       (score),
      .state       (state),
      .game_over   (game_over),
      .win         (win)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   // Expected snapshot; the per-state output flags follow from the state code
   function automatic exp_t mk(input logic [2:0] st, input logic [2:0] lv,
                               input logic [5:0] bk, input logic [15:0] sc);
      exp_t r;
      r.st = st;
      r.bo = !((st == 3'd2) || (st == 3'd3));
      r.br = (st == 3'd2);
      r.go = (st == 3'd4);
      r.wn = (st == 3'd5);
      r.lv = lv;
      r.bk = bk;
      r.sc = sc;
      return r;
   endfunction

   function automatic exp_t sample();
      exp_t r;
      r.st = state;
      r.bo = ball_out;
      r.br = ball_run;
      r.go = game_over;
      r.wn = win;
      r.lv = lives;
      r.bk = bricks_left;
      r.sc = score;
      return r;
   endfunction

   task automatic cyc(input logic [7:0] k, input logic m, input logic h);
      keycode   = k;
      ball_miss = m;
      brick_hit = h;
      @(posedge frame_clk);
      @(negedge frame_clk);
   endtask

   task automatic do_reset();
      @(negedge frame_clk);
      keycode   = 8'h00;
      ball_miss = 1'b0;
      brick_hit = 1'b0;
      Reset     = 1'b1;
      #2;
      Reset     = 1'b0;
   endtask

   task automatic go_play();
      do_reset();
      cyc(SP, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b0);
      cyc(SP, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      Reset = 1'b1; keycode = 8'h00; ball_miss = 1'b0; brick_hit = 1'b0;
      #1;
      exp_q.push_back(mk(3'd0, 3'd3, 6'd40, 16'd0));
      e = exp_q.pop_front(); got = sample(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
      @(negedge frame_clk);
      Reset = 1'b0;
      exp_q.push_back(mk(3'd0, 3'd3, 6'd40, 16'd0));
      cyc(8'h00, 1'b0, 1'b1);
      e = exp_q.pop_front(); got = sample(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_first_edge got=%h exp=%h", got, e); end
   endtask

   task automatic test_serve();
      do_reset();
      for (int i = 0; i <= 60; i++) begin
         exp_q.push_back(mk((i < 60) ? 3'd1 : 3'd2, 3'd3, 6'd40, 16'd0));
         cyc((i < 10) ? SP : 8'h00, 1'b0, 1'b0);
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL serve_frame%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_miss();
      logic [7:0] ks[7]  = '{8'h00, SP, 8'h00, 8'h00, SP, 8'h00, 8'h00};
      logic       ms[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0] sts[7] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd2, 3'd2, 3'd4};
      logic [2:0] lvs[7] = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0};
      go_play();
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(mk(sts[i], lvs[i], 6'd40, 16'd0));
         cyc(ks[i], ms[i], 1'b0);
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL miss_step%0d got=%h exp=%h", i, got, e); end
      end
      // Hold frames: presses at 50 and 119 are too early, 121 is the first accepted
      for (int k = 1; k <= 121; k++) begin
         if (k < 121) exp_q.push_back(mk(3'd4, 3'd0, 6'd40, 16'd0));
         else         exp_q.push_back(mk(3'd0, 3'd3, 6'd40, 16'd0));
         cyc((k == 50 || k == 119 || k == 121) ? SP : 8'h00, 1'b1, 1'b1);
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL over_hold%0d got=%h exp=%h", k, got, e); end
      end
   endtask

   task automatic test_win();
      go_play();
      for (int i = 1; i <= 39; i++) begin
         exp_q.push_back(mk(3'd2, 3'd3, 6'(40 - i), 16'(10 * i)));
         cyc(8'h00, 1'b0, 1'b1);
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL win_hit%0d got=%h exp=%h", i, got, e); end
      end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(3'd5, 3'd3, 6'd0, 16'd400));
         cyc((i == 2) ? SP : 8'h00, 1'b1, 1'b1);
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL win_final%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_pause();
      logic [7:0]  ks[8]  = '{PK, PK, 8'h00, PK, 8'h00, PK, 8'h00, PK};
      logic        ms[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        hs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  sts[8] = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
      logic [5:0]  bks[8] = '{6'd40, 6'd40, 6'd40, 6'd40, 6'd40, 6'd39, 6'd39, 6'd39};
      logic [15:0] scs[8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd10, 16'd10, 16'd10};
      go_play();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mk(sts[i], 3'd3, bks[i], scs[i]));
         cyc(ks[i], ms[i], hs[i]);
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL pause_step%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_saturate();
      go_play();
      force dut.score = 16'hFFFA;
      #1;
      release dut.score;
      exp_q.push_back(mk(3'd2, 3'd3, 6'd39, 16'hFFFF));
      cyc(8'h00, 1'b0, 1'b1);
      e = exp_q.pop_front(); got = sample(); total++;
      if (got !== e) begin bad++; $display("FAIL sat_first got=%h exp=%h", got, e); end
      exp_q.push_back(mk(3'd2, 3'd3, 6'd38, 16'hFFFF));
      cyc(8'h00, 1'b0, 1'b1);
      e = exp_q.pop_front(); got = sample(); total++;
      if (got !== e) begin bad++; $display("FAIL sat_hold got=%h exp=%h", got, e); end
   endtask

   task automatic test_reset_mid_serve();
      do_reset();
      cyc(SP, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cyc(8'h00, 1'b0, 1'b0);
      #2;
      Reset = 1'b1;
      #1;
      exp_q.push_back(mk(3'd0, 3'd3, 6'd40, 16'd0));
      e = exp_q.pop_front(); got = sample(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_async got=%h exp=%h", got, e); end
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 70; i++) begin
         exp_q.push_back(mk(3'd0, 3'd3, 6'd40, 16'd0));
         cyc(8'h00, 1'b1, 1'b1);
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL reset_idle%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_back_to_back();
      go_play();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(3'd1, 3'd2, 6'd39, 16'd10));
         cyc(8'h00, (i != 1), (i != 2));
         e = exp_q.pop_front(); got = sample(); total++;
         if (got !== e) begin bad++; $display("FAIL b2b_step%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_miss();
      test_win();
      test_pause();
      test_saturate();
      test_reset_mid_serve();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
